ramblock_nx_swrite_dread: RTL
=============================

Name: ramblock_nx_swrite_dread

Overview:
- Parametrised single-clock RAM block: one synchronous write port, two independent synchronous read ports (DO1, DO2).
- Generalises the fixed 9-bit x 256-word dual-read RAM cell to configurable width and depth.
- Adds three behaviours: a selectable read-during-write policy, an optional output register, and a post-reset memory-clear sweep.
- Sits under the cell_* wrapper layer as the storage primitive for buffering blocks.

Parameters:
- DW, 9, data word width in bits.
- AW, 8, address width in bits.
- DEPTH, 256, number of words; must be ≤ 2**AW; need not be a power of 2.
- OUT_REG, 0, 1 = extra output register stage (read latency 2); 0 = read latency 1.

Ports:
- CLKS  in  1  sole clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- DIn  in  DW  write data.
- WADDR  in  AW  write address.
- WRB  in  1  write enable, active low.
- RADDR1  in  AW  read address, port 1.
- RDB1  in  1  read enable, port 1, active low.
- RADDR2  in  AW  read address, port 2.
- RDB2  in  1  read enable, port 2, active low.
- MODE  in  2  read-during-write policy, sampled every cycle.
- DO1  out  DW  read data, port 1.
- DV1  out  1  DO1 valid strobe.
- DO2  out  DW  read data, port 2.
- DV2  out  1  DO2 valid strobe.
- BUSY  out  1  clear sweep in progress.
- COLL  out  2  per-port same-address collision flag, aligned with DVk.

Behaviour:
- Reset values: DO1=DO2=0, DV1=DV2=0, COLL=0, BUSY=1; FSM enters INIT with clear pointer = 0.
- RST asserted at any time, including mid-INIT or mid-read, restarts the sweep from 0 and kills all in-flight reads.
- FSM states: INIT, READY.
- INIT:
  - Each cycle writes 0 to mem[ptr] and increments ptr.
  - When ptr == DEPTH-1 is written, the FSM moves to READY on the next edge.
  - Sweep lasts exactly DEPTH cycles after reset release; BUSY falls on the cycle READY is entered.
  - User writes are dropped and reads are ignored; DVk stays 0.
- READY, write: WRB=0 and WADDR < DEPTH → mem[WADDR] <= DIn. WADDR ≥ DEPTH → write silently dropped.
- READY, read port k:
  - RDBk=0 → DOk valid L cycles later, where L = 1 + OUT_REG.
  - DVk is a 1-cycle pulse aligned with the data.
  - Back-to-back reads are fully pipelined, one result per cycle per port.
  - RADDRk ≥ DEPTH → DOk = 0 with DVk = 1.
  - DOk holds its last value when no read completes.
- Collision (same cycle, WRB=0, RDBk=0, RADDRk == WADDR < DEPTH), resolved by MODE:
  - 00 read-old: DOk = previous contents.
  - 01 write-through: DOk = DIn.
  - 10 masked: DOk = 0.
  - 11 reserved: behaves as 00.
- COLL[k-1] is asserted with DVk for any collision, regardless of MODE.
- Both ports may read the same address in the same cycle; each resolves the collision independently.

Optional Feature:
- Macro: RAMBLOCK_PARITY_EN.
- With the macro defined:
  - Each word stores an extra even-parity bit computed from DIn; the INIT sweep writes parity 0.
  - Extra outputs PERR1 and PERR2 (1 bit each), aligned with DVk, assert when the stored word fails its parity check.
  - Write-through and masked results always report PERR = 0.
  - Reset value of PERR1/PERR2 is 0.
- Without the macro: PERR ports and parity storage are absent.

Decomposition:
- Package ramblock_pkg holds:
  - state enum {INIT, READY};
  - MODE constants MODE_RD_OLD = 2'b00, MODE_WR_THRU = 2'b01, MODE_MASK = 2'b10;
  - a parity function.
- Sub-module ramblock_rd_port (instantiated twice) holds:
  - address range check;
  - collision mux;
  - OUT_REG pipeline;
  - DV/COLL/PERR alignment.
- The top level holds the memory array, the write logic and the INIT FSM.

Test Plan:
- Reset → BUSY=1 for exactly 256 cycles (defaults); read every address afterwards → all DOk = 0, DVk = 1.
- Write 0x1A5 @ 0x10, then read @ 0x10 on port 1, OUT_REG=0 → DO1 = 0x1A5 one cycle later, DV1 a single pulse; with OUT_REG=1 → two cycles later.
- Mem[0x20] = 0x055; write 0x0AA @ 0x20 while both ports read 0x20:
  - MODE=00 → DO = 0x055;
  - MODE=01 → DO = 0x0AA;
  - MODE=10 → DO = 0;
  - COLL = 2'b11 in every case.
- DEPTH=200: write 0x1FF @ 0xC8, then read @ 0xC8 → DO = 0, DV = 1; mem[0] is unchanged.
- RST pulsed at cycle 100 of INIT, and again during a pending read → BUSY stays 1 for 256 cycles after release; no DV pulse emerges.
- RAMBLOCK_PARITY_EN: write 0x003, force one stored bit flipped, read → PERR1 = 1 with DV1; an unflipped word → PERR1 = 0.

Source files
------------

// File: rtl/ramblock_pkg.sv
// Shared state type, read-during-write policy codes and parity helper for the dual-read RAM block.
// Pure declarations: no latency, no flow control.
package ramblock_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [1:0] MODE_RD_OLD  = 2'b00;
    localparam logic [1:0] MODE_WR_THRU = 2'b01;
    localparam logic [1:0] MODE_MASK    = 2'b10;

    localparam int PAR_MAX_W = 64;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic f_even_par(input logic [PAR_MAX_W-1:0] i_v);
        return ^i_v;
    endfunction

endpackage

// File: rtl/ramblock_rd_port.sv
// One read port: address range check, read-during-write resolution, optional output stage.
// Latency 1 + OUT_REG cycles; no backpressure, fully pipelined at one result per cycle.
module ramblock_rd_port
    import ramblock_pkg::*;
#(
    parameter int DW      = 9,
    parameter int AW      = 8,
    parameter int DEPTH   = 256,
    parameter int OUT_REG = 0,
    parameter int MW      = DW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_raddr,
    input  logic [MW-1:0] i_rdata,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [1:0]    i_mode,
    output logic [DW-1:0] o_do,
    output logic          o_dv,
    output logic          o_coll
`ifdef RAMBLOCK_PARITY_EN
    ,
    output logic          o_perr
`endif
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic          w_in_rng;
    logic          w_coll;
    logic [DW-1:0] w_dat;
    logic          r_s1_dv;
    logic          r_s1_coll;
    logic [DW-1:0] r_s1_do;

    assign w_in_rng = ({1'b0, i_raddr} < LP_DEPTH);
    // i_wr_en is already range-qualified, so an address match implies an in-range collision.
    assign w_coll   = i_rd_en & i_wr_en & (i_raddr == i_waddr);

    always_comb begin
        w_dat = i_rdata[DW-1:0];
        if (!w_in_rng) begin
            w_dat = '0;
        end else if (w_coll) begin
            case (i_mode)
                MODE_WR_THRU: w_dat = i_wdata;
                MODE_MASK:    w_dat = '0;
                default:      w_dat = i_rdata[DW-1:0];
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_dv   <= 1'b0;
            r_s1_coll <= 1'b0;
            r_s1_do   <= '0;
        end else begin
            r_s1_dv   <= i_rd_en;
            r_s1_coll <= w_coll;
            if (i_rd_en) begin
                r_s1_do <= w_dat;
            end
        end
    end

`ifdef RAMBLOCK_PARITY_EN
    logic w_perr;
    logic r_s1_perr;

    // Only a genuine array read can report a parity failure.
    assign w_perr = w_in_rng & ~(w_coll & (i_mode == MODE_WR_THRU || i_mode == MODE_MASK))
                    & (^i_rdata);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_perr <= 1'b0;
        end else begin
            r_s1_perr <= i_rd_en & w_perr;
        end
    end
`endif

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic          r_s2_dv;
            logic          r_s2_coll;
            logic [DW-1:0] r_s2_do;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_s2_dv   <= 1'b0;
                    r_s2_coll <= 1'b0;
                    r_s2_do   <= '0;
                end else begin
                    r_s2_dv   <= r_s1_dv;
                    r_s2_coll <= r_s1_coll;
                    if (r_s1_dv) begin
                        r_s2_do <= r_s1_do;
                    end
                end
            end

            assign o_do   = r_s2_do;
            assign o_dv   = r_s2_dv;
            assign o_coll = r_s2_coll;
`ifdef RAMBLOCK_PARITY_EN
            logic r_s2_perr;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_s2_perr <= 1'b0;
                end else begin
                    r_s2_perr <= r_s1_perr;
                end
            end
            assign o_perr = r_s2_perr;
`endif
        end else begin : g_noreg
            assign o_do   = r_s1_do;
            assign o_dv   = r_s1_dv;
            assign o_coll = r_s1_coll;
`ifdef RAMBLOCK_PARITY_EN
            assign o_perr = r_s1_perr;
`endif
        end
    endgenerate

endmodule

// File: rtl/ramblock_nx_swrite_dread.sv
// Parametrised RAM, one write and two read ports, post-reset clear sweep; RAMBLOCK_PARITY_EN adds per-word parity.
// Read latency 1 + OUT_REG; no backpressure, accesses are ignored while BUSY is high.
module ramblock_nx_swrite_dread
    import ramblock_pkg::*;
#(
    parameter int DW      = 9,
    parameter int AW      = 8,
    parameter int DEPTH   = 256,
    parameter int OUT_REG = 0
) (
    input  logic          CLKS,
    input  logic          RST,
    input  logic [DW-1:0] DIn,
    input  logic [AW-1:0] WADDR,
    input  logic          WRB,
    input  logic [AW-1:0] RADDR1,
    input  logic          RDB1,
    input  logic [AW-1:0] RADDR2,
    input  logic          RDB2,
    input  logic [1:0]    MODE,
    output logic [DW-1:0] DO1,
    output logic          DV1,
    output logic [DW-1:0] DO2,
    output logic          DV2,
    output logic          BUSY,
    output logic [1:0]    COLL
`ifdef RAMBLOCK_PARITY_EN
    ,
    output logic          PERR1,
    output logic          PERR2
`endif
);

`ifdef RAMBLOCK_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif
    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;
    logic          w_clr_en;
    logic          w_ready;
    logic          w_wr_en;
    logic          w_rd_en1;
    logic          w_rd_en2;
    logic [MW-1:0] w_wr_word;
    logic [MW-1:0] w_rd_word1;
    logic [MW-1:0] w_rd_word2;
    logic          w_coll1;
    logic          w_coll2;
    logic [MW-1:0] r_mem [DEPTH];

    assign w_ready  = (r_state == READY);
    assign BUSY     = ~w_ready;
    assign w_wr_en  = w_ready & ~WRB & ({1'b0, WADDR} < LP_DEPTH);
    assign w_rd_en1 = w_ready & ~RDB1;
    assign w_rd_en2 = w_ready & ~RDB2;
    assign COLL     = {w_coll2, w_coll1};

`ifdef RAMBLOCK_PARITY_EN
    assign w_wr_word = {f_even_par(64'(DIn)), DIn};
`else
    assign w_wr_word = DIn;
`endif

    always_ff @(posedge CLKS or posedge RST) begin
        if (RST) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_clr_en    = 1'b0;
        case (r_state)
            INIT: begin
                w_clr_en  = 1'b1;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == LP_LAST) begin
                    w_state_nxt = READY;
                    w_ptr_nxt   = '0;
                end
            end
            READY:   w_state_nxt = READY;
            default: w_state_nxt = INIT;
        endcase
    end

    // The array has no reset; the INIT sweep is what clears it.
    always_ff @(posedge CLKS) begin
        if (w_clr_en) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[WADDR] <= w_wr_word;
        end
    end

    assign w_rd_word1 = r_mem[RADDR1];
    assign w_rd_word2 = r_mem[RADDR2];

    ramblock_rd_port #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .OUT_REG(OUT_REG), .MW(MW)
    ) u_rd1 (
        .i_clk   (CLKS),
        .i_rst   (RST),
        .i_rd_en (w_rd_en1),
        .i_raddr (RADDR1),
        .i_rdata (w_rd_word1),
        .i_wr_en (w_wr_en),
        .i_waddr (WADDR),
        .i_wdata (DIn),
        .i_mode  (MODE),
        .o_do    (DO1),
        .o_dv    (DV1),
        .o_coll  (w_coll1)
`ifdef RAMBLOCK_PARITY_EN
        ,
        .o_perr  (PERR1)
`endif
    );

    ramblock_rd_port #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .OUT_REG(OUT_REG), .MW(MW)
    ) u_rd2 (
        .i_clk   (CLKS),
        .i_rst   (RST),
        .i_rd_en (w_rd_en2),
        .i_raddr (RADDR2),
        .i_rdata (w_rd_word2),
        .i_wr_en (w_wr_en),
        .i_waddr (WADDR),
        .i_wdata (DIn),
        .i_mode  (MODE),
        .o_do    (DO2),
        .o_dv    (DV2),
        .o_coll  (w_coll2)
`ifdef RAMBLOCK_PARITY_EN
        ,
        .o_perr  (PERR2)
`endif
    );

endmodule
